// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and sizing constants for the instruction fetch buffer.
// Holds the fetch entry payload and the default queue/in-flight depths.
package instr_fetch_buffer_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam int unsigned FQ_DEPTH     = 2;
    localparam int unsigned IMEM_MAX_OUT = 2;
    localparam int unsigned ENTRY_W      = $bits(fetch_entry_t);

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous clear and full/empty/count.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data-only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !clr) r_mem[r_wptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues imem requests under a credit rule, pairs
// in-order responses with their PCs, queues them for decode, and handles flush.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned QDEPTH  = FQ_DEPTH,
    parameter int unsigned MAX_OUT = IMEM_MAX_OUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            dec_ready,
    output logic            rsp_err
);

    localparam int unsigned OW = cnt_width(MAX_OUT);
    localparam int unsigned QW = cnt_width(QDEPTH);
    localparam int unsigned SW = ((OW > QW) ? OW : QW) + 1;

    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop_cnt;
    logic            r_rsp_err;

    logic            w_credit;
    logic            w_hs;
    logic            w_rsp_ok;
    logic            w_rsp_pop;
    logic [XLEN-1:0] w_rsp_pc;

    logic            w_if_push;
    logic            w_if_pop;
    logic [XLEN-1:0] w_if_pc;
    logic            w_if_full;
    logic            w_if_empty;
    logic [OW-1:0]   w_if_count;

    logic            w_q_push;
    logic            w_q_pop;
    fetch_entry_t    w_q_wdata;
    fetch_entry_t    w_q_rdata;
    logic            w_q_full;
    logic            w_q_empty;
    logic [QW-1:0]   w_q_count;
    logic            w_unused;

    // Every in-flight request already owns a queue slot, so the queue cannot overflow.
    assign w_credit = (SW'(r_outstanding) + SW'(w_q_count)) < SW'(QDEPTH);

    assign imem_req_valid = !rst && !flush && (r_outstanding < OW'(MAX_OUT)) && w_credit;
    assign imem_req_addr  = pc_in;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign pc_en          = w_hs;

    // A same-cycle handshake counts as outstanding so zero-latency memory works.
    assign w_rsp_ok  = imem_rsp_valid && !rst && ((r_outstanding != '0) || w_hs);
    assign w_rsp_pop = w_rsp_ok && (r_drop_cnt == '0);

    // With the in-flight FIFO empty, a kept response belongs to this cycle's request.
    assign w_rsp_pc  = w_if_empty ? pc_in : w_if_pc;
    assign w_if_pop  = w_rsp_pop && !w_if_empty;
    assign w_if_push = w_hs && !(w_rsp_pop && w_if_empty);

    assign w_q_wdata.pc    = w_rsp_pc;
    assign w_q_wdata.instr = imem_rsp_data;
    assign w_q_push        = w_rsp_pop && !flush;
    assign w_q_pop         = dec_valid && dec_ready;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_if_push),
        .push_data (pc_in),
        .pop       (w_if_pop),
        .pop_data  (w_if_pc),
        .full      (w_if_full),
        .empty     (w_if_empty),
        .count     (w_if_count)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_q_push),
        .push_data (w_q_wdata),
        .pop       (w_q_pop),
        .pop_data  (w_q_rdata),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    assign w_unused = ^{w_if_full, w_if_count, w_q_full};

    // Outstanding already includes responses owed to earlier flushes, so a
    // flush reloads drop_cnt from outstanding alone rather than accumulating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_hs) - OW'(w_rsp_ok);
            if (flush) begin
                r_drop_cnt <= r_outstanding - OW'(w_rsp_ok);
            end else if (w_rsp_ok && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - OW'(1);
            end
            if (imem_rsp_valid && !w_rsp_ok) r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err   = r_rsp_err;
    assign dec_valid = !w_q_empty && !rst;
    assign dec_instr = dec_valid ? w_q_rdata.instr : '0;
    assign dec_pc    = dec_valid ? w_q_rdata.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a behavioural PC and imem model.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 0;
    bit mem_hold = 1'b0;
    int mem_rel = 0;
    bit inject = 1'b0;
    int req_cnt = 0;
    logic [31:0] pq_addr[$];
    int          pq_cyc[$];

    always #5 clk = ~clk;

    instr_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_en          (pc_en),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .rsp_err        (rsp_err)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: model the memory, then advance the PC if a fetch was accepted.
    task automatic step();
        logic hs;
        logic adv;
        #1;
        hs = imem_req_valid && imem_req_ready;
        if (hs) begin
            pq_addr.push_back(imem_req_addr);
            pq_cyc.push_back(cyc);
            req_cnt++;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            inject = 1'b0;
        end else if (pq_addr.size() > 0 && (!mem_hold || mem_rel > 0) &&
                     cyc >= pq_cyc[0] + mem_lat) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pq_addr[0]);
            void'(pq_addr.pop_front());
            void'(pq_cyc.pop_front());
            if (mem_hold) mem_rel--;
        end
        adv = pc_en;
        @(posedge clk);
        #1;
        cyc++;
        if (adv) pc_in = pc_in + 32'd4;
    endtask

    task automatic expect_next(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (!dec_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " valid"}, 32'(dec_valid), 32'd1);
        if (dec_valid) begin
            chk({tag, " pc"}, dec_pc, exp_pc);
            chk({tag, " instr"}, dec_instr, instr_of(exp_pc));
        end
        step();
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b1;
        flush = 1'b0;
        mem_hold = 1'b0;
        mem_rel = 0;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        step();
        step();
        pq_addr.delete();
        pq_cyc.delete();
        rst = 1'b0;
        pc_in = start_pc;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        pc_in = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        dec_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst dec_valid", 32'(dec_valid), 32'd0);
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst pc_en", 32'(pc_en), 32'd0);
        chk("rst dec_pc", dec_pc, 32'd0);
        chk("rst dec_instr", dec_instr, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);

        // Zero-latency streaming: one instruction per cycle
        mem_lat = 0;
        rst = 1'b0;
        settle();
        chk("stream pc_en0", 32'(pc_en), 32'd1);
        chk("stream dec_valid0", 32'(dec_valid), 32'd0);
        chk("stream addr0", imem_req_addr, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream dec_valid", 32'(dec_valid), 32'd1);
            chk("stream dec_pc", dec_pc, 32'(i * 4));
            chk("stream pc_en", 32'(pc_en), 32'd1);
            step();
        end

        // Decode stalled with 1-cycle memory: credit caps at two requests
        do_reset(32'h0);
        mem_lat = 1;
        dec_ready = 1'b0;
        req_cnt = 0;
        repeat (6) step();
        chk("stall req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall req_cnt", 32'(req_cnt), 32'd2);
        chk("stall pc_in", pc_in, 32'h8);
        chk("stall dec_pc", dec_pc, 32'h0);
        step();
        chk("stall hold pc", dec_pc, 32'h0);
        chk("stall hold instr", dec_instr, instr_of(32'h0));
        dec_ready = 1'b1;
        expect_next("stall e0", 32'h0);
        expect_next("stall e1", 32'h4);
        expect_next("stall e2", 32'h8);

        // Two outstanding, then flush: both responses discarded
        do_reset(32'h8);
        mem_lat = 0;
        mem_hold = 1'b1;
        step();
        step();
        chk("fl2 out cap", 32'(imem_req_valid), 32'd0);
        flush = 1'b1;
        pc_in = 32'h40;
        settle();
        chk("fl2 flush req", 32'(imem_req_valid), 32'd0);
        chk("fl2 flush pc_en", 32'(pc_en), 32'd0);
        step();
        flush = 1'b0;
        mem_hold = 1'b0;
        expect_next("fl2 tgt", 32'h40);
        expect_next("fl2 tgt+4", 32'h44);
        chk("fl2 rsp_err", 32'(rsp_err), 32'd0);

        // Flush coinciding with the first response: only the second is dropped
        do_reset(32'h8);
        mem_hold = 1'b1;
        step();
        step();
        flush = 1'b1;
        pc_in = 32'h40;
        mem_rel = 1;
        step();
        flush = 1'b0;
        mem_hold = 1'b0;
        expect_next("flrsp tgt", 32'h40);

        // Back-to-back flushes: only the final target is fetched
        do_reset(32'h8);
        mem_hold = 1'b1;
        step();
        step();
        flush = 1'b1;
        pc_in = 32'h80;
        step();
        pc_in = 32'h100;
        settle();
        chk("flx2 req", 32'(imem_req_valid), 32'd0);
        step();
        flush = 1'b0;
        mem_hold = 1'b0;
        expect_next("flx2 tgt", 32'h100);

        // Flush with a full queue empties it and refetches at once
        do_reset(32'h0);
        mem_lat = 1;
        dec_ready = 1'b0;
        repeat (5) step();
        chk("flq full", 32'(dec_valid), 32'd1);
        flush = 1'b1;
        pc_in = 32'h200;
        step();
        flush = 1'b0;
        settle();
        chk("flq empty", 32'(dec_valid), 32'd0);
        chk("flq req", 32'(imem_req_valid), 32'd1);
        chk("flq addr", imem_req_addr, 32'h200);
        dec_ready = 1'b1;
        expect_next("flq tgt", 32'h200);

        // Reset with two outstanding requests
        do_reset(32'h8);
        mem_lat = 0;
        mem_hold = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rso dec_valid", 32'(dec_valid), 32'd0);
        chk("rso req_valid", 32'(imem_req_valid), 32'd0);
        pq_addr.delete();
        pq_cyc.delete();
        rst = 1'b0;
        mem_hold = 1'b0;
        pc_in = 32'h0;
        settle();
        chk("rso req after", 32'(imem_req_valid), 32'd1);
        expect_next("rso fetch0", 32'h0);

        // Reset with a full queue
        mem_lat = 1;
        dec_ready = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pq_addr.delete();
        pq_cyc.delete();
        pc_in = 32'h0;
        settle();
        chk("rsq dec_valid", 32'(dec_valid), 32'd0);
        dec_ready = 1'b1;
        expect_next("rsq fetch0", 32'h0);
        chk("rsq rsp_err", 32'(rsp_err), 32'd0);

        // Spurious response with nothing outstanding
        do_reset(32'h300);
        mem_lat = 0;
        dec_ready = 1'b0;
        step();
        imem_req_ready = 1'b0;
        chk("err pre valid", 32'(dec_valid), 32'd1);
        chk("err pre rsp_err", 32'(rsp_err), 32'd0);
        inject = 1'b1;
        step();
        chk("err set", 32'(rsp_err), 32'd1);
        chk("err q pc", dec_pc, 32'h300);
        step();
        step();
        chk("err sticky", 32'(rsp_err), 32'd1);
        dec_ready = 1'b1;
        step();
        chk("err q drained", 32'(dec_valid), 32'd0);

        // Stale response arriving after a mid-flight reset
        do_reset(32'h0);
        chk("stale clr", 32'(rsp_err), 32'd0);
        mem_hold = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("stale pre", 32'(rsp_err), 32'd0);
        mem_hold = 1'b0;
        step();
        chk("stale set", 32'(rsp_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
